// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: arbiter state encoding and requester port ids shared by mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// mem_port_arbiter_mux2: WIDTH-bit 2:1 mux, y = control ? d1 : d0
module mem_port_arbiter_mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             control,
  output logic [WIDTH-1:0] y
);
  assign y = control ? d1 : d0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding memory port shared by fetch (m0_*) and load/store (m1_*); mem_* to memory, mem_sel/busy/err_unexp status
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_sel,
  output logic            busy,
  output logic            err_unexp
);
  arb_state_t state, state_nxt;
  logic owner, owner_nxt, last_grant, last_nxt, winner, rsp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= PORT_IF;
      last_grant <= PORT_LS;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
    end
  end
  always_comb begin
    winner    = m1_valid && (!m0_valid || !RR_EN || last_grant == PORT_IF);
    mem_valid = state == ISSUE;
    rsp       = state == WAIT && mem_rvalid;
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_grant;
    if (state == IDLE && (m0_valid || m1_valid)) begin
      state_nxt = ISSUE;
      owner_nxt = winner;
    end
    if (mem_valid && mem_ready) begin
      state_nxt = WAIT;
      last_nxt  = owner;
    end
    if (rsp) state_nxt = IDLE;
    m0_ready  = mem_valid && mem_ready && owner == PORT_IF;
    m1_ready  = mem_valid && mem_ready && owner == PORT_LS;
    m0_rvalid = rsp && owner == PORT_IF;
    m1_rvalid = rsp && owner == PORT_LS;
    busy      = state != IDLE;
    err_unexp = rst_n && mem_rvalid && state != WAIT;
  end
  assign mem_sel  = owner;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;
  mem_port_arbiter_mux2 #(.WIDTH(AW)) u_addr (
    .d0(m0_addr), .d1(m1_addr), .control(mem_sel), .y(mem_addr)
  );
  mem_port_arbiter_mux2 #(.WIDTH(DW)) u_wdata (
    .d0(m0_wdata), .d1(m1_wdata), .control(mem_sel), .y(mem_wdata)
  );
  mem_port_arbiter_mux2 #(.WIDTH(1)) u_we (
    .d0(m0_we), .d1(m1_we), .control(mem_sel), .y(mem_we)
  );
  mem_port_arbiter_mux2 #(.WIDTH(DW/8)) u_be (
    .d0(m0_be), .d1(m1_be), .control(mem_sel), .y(mem_be)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed + random check of round-robin and fixed-priority arbiters against a transaction model
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic m0_valid = 1'b0, m1_valid = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, mem_rdata = '0;
  logic [BW-1:0] m0_be = '0, m1_be = '0;
  logic m0_ready[2], m1_ready[2], m0_rvalid[2], m1_rvalid[2];
  logic mem_valid[2], mem_we[2], mem_sel[2], busy[2], err_unexp[2];
  logic [DW-1:0] m0_rdata[2], m1_rdata[2], mem_wdata[2];
  logic [AW-1:0] mem_addr[2];
  logic [BW-1:0] mem_be[2];
  bit pend[2], acc[2], own[2], last[2], cons[2];
  logic [7:0] ghist[2];
  int rvcnt[2][2];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < 2; i++) begin : g_dut
    mem_port_arbiter #(.AW(AW), .DW(DW), .RR_EN(i == 0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_valid(m0_valid), .m0_ready(m0_ready[i]), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_we(m0_we), .m0_be(m0_be), .m0_rvalid(m0_rvalid[i]), .m0_rdata(m0_rdata[i]),
      .m1_valid(m1_valid), .m1_ready(m1_ready[i]), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_we(m1_we), .m1_be(m1_be), .m1_rvalid(m1_rvalid[i]), .m1_rdata(m1_rdata[i]),
      .mem_valid(mem_valid[i]), .mem_ready(mem_ready), .mem_addr(mem_addr[i]),
      .mem_wdata(mem_wdata[i]), .mem_we(mem_we[i]), .mem_be(mem_be[i]),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_sel(mem_sel[i]), .busy(busy[i]), .err_unexp(err_unexp[i])
    );
  end
  task automatic chk(input int k, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0;
      acc[k]  = 1'b0;
      own[k]  = 1'b0;
      last[k] = 1'b1;
      cons[k] = 1'b0;
    end
  endtask
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      logic ev, rv;
      ev = pend[k] && !acc[k];
      rv = acc[k] && mem_rvalid;
      chk(k, "mem_valid", 64'(mem_valid[k]), 64'(ev));
      chk(k, "busy", 64'(busy[k]), 64'(pend[k]));
      chk(k, "mem_sel", 64'(mem_sel[k]), 64'(own[k]));
      chk(k, "m0_ready", 64'(m0_ready[k]), 64'(ev && mem_ready && !own[k]));
      chk(k, "m1_ready", 64'(m1_ready[k]), 64'(ev && mem_ready && own[k]));
      chk(k, "m0_rvalid", 64'(m0_rvalid[k]), 64'(rv && !own[k]));
      chk(k, "m1_rvalid", 64'(m1_rvalid[k]), 64'(rv && own[k]));
      chk(k, "err_unexp", 64'(err_unexp[k]), 64'(rst_n && mem_rvalid && !acc[k]));
      chk(k, "mem_addr", 64'(mem_addr[k]), 64'(own[k] ? m1_addr : m0_addr));
      chk(k, "mem_wdata", 64'(mem_wdata[k]), 64'(own[k] ? m1_wdata : m0_wdata));
      chk(k, "mem_we", 64'(mem_we[k]), 64'(own[k] ? m1_we : m0_we));
      chk(k, "mem_be", 64'(mem_be[k]), 64'(own[k] ? m1_be : m0_be));
      chk(k, "m0_rdata", 64'(m0_rdata[k]), 64'(mem_rdata));
      chk(k, "m1_rdata", 64'(m1_rdata[k]), 64'(mem_rdata));
      if (mem_valid[k] && mem_ready) ghist[k] = {ghist[k][6:0], mem_sel[k]};
      if (m0_rvalid[k]) rvcnt[k][0]++;
      if (m1_rvalid[k]) rvcnt[k][1]++;
    end
    if (rst_n && pend[0] && !acc[0])
      assert (own[0] ? m1_valid : m0_valid) else $error("protocol: owner dropped valid during issue");
    @(posedge clk);
    cons[0] = 1'b0;
    cons[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend[k] = 1'b0;
        acc[k]  = 1'b0;
        own[k]  = 1'b0;
        last[k] = 1'b1;
      end else if (!pend[k]) begin
        if (m0_valid || m1_valid) begin
          pend[k] = 1'b1;
          own[k]  = (m0_valid && m1_valid) ? (k == 0 ? !last[k] : 1'b1) : m1_valid;
        end
      end else if (!acc[k]) begin
        if (mem_ready) begin
          acc[k]  = 1'b1;
          last[k] = own[k];
          if (k == 0) cons[own[k]] = 1'b1;
        end
      end else if (mem_rvalid) begin
        pend[k] = 1'b0;
        acc[k]  = 1'b0;
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    #2;
    do_reset();
    m0_valid = 1'b1;
    m0_addr = 32'h0000_0100;
    m0_be = 4'hf;
    mem_ready = 1'b1;
    tick();
    #1;
    chk(0, "fetch_mem_valid", 64'(mem_valid[0]), 64'(1'b1));
    chk(0, "fetch_ready", 64'(m0_ready[0]), 64'(1'b1));
    chk(0, "fetch_addr", 64'(mem_addr[0]), 64'h100);
    tick();
    m0_valid = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk(0, "fetch_rvalid", 64'(m0_rvalid[0]), 64'(1'b1));
    chk(0, "fetch_rdata", 64'(m0_rdata[0]), 64'hDEAD_BEEF);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk(0, "fetch_busy_low", 64'(busy[0]), 64'(1'b0));
    tick();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ghist[k] = '0;
      rvcnt[k][0] = 0;
      rvcnt[k][1] = 0;
    end
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    m0_addr = 32'h200;
    m1_addr = 32'h300;
    mem_ready = 1'b1;
    repeat (12) begin
      mem_rvalid = acc[0];
      mem_rdata = $urandom();
      tick();
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    mem_rvalid = 1'b0;
    chk(0, "rr_order", 64'(ghist[0][3:0]), 64'(4'b0101));
    chk(0, "rr_rv_port0", 64'(rvcnt[0][0]), 64'd2);
    chk(0, "rr_rv_port1", 64'(rvcnt[0][1]), 64'd2);
    chk(1, "fp_order", 64'(ghist[1][3:0]), 64'(4'b1111));
    chk(1, "fp_rv_port0", 64'(rvcnt[1][0]), 64'd0);
    chk(1, "fp_rv_port1", 64'(rvcnt[1][1]), 64'd4);
    tick();
    m1_valid = 1'b1;
    m1_we = 1'b1;
    m1_be = 4'b0011;
    m1_wdata = 32'h1234_5678;
    m1_addr = 32'h400;
    mem_ready = 1'b0;
    tick();
    repeat (3) begin
      #1;
      chk(0, "st_mem_valid", 64'(mem_valid[0]), 64'(1'b1));
      chk(0, "st_wdata", 64'(mem_wdata[0]), 64'h1234_5678);
      chk(0, "st_be", 64'(mem_be[0]), 64'(4'b0011));
      chk(0, "st_stall_ready", 64'(m1_ready[0]), 64'(1'b0));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk(0, "st_accept_ready", 64'(m1_ready[0]), 64'(1'b1));
    tick();
    m1_valid = 1'b0;
    m1_we = 1'b0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    chk(0, "st_ack", 64'(m1_rvalid[0]), 64'(1'b1));
    tick();
    mem_rvalid = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    #1;
    chk(0, "spur_err", 64'(err_unexp[0]), 64'(1'b1));
    chk(0, "spur_rvalid", 64'({m0_rvalid[0], m1_rvalid[0]}), 64'(2'b00));
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk(0, "spur_err_pulse", 64'(err_unexp[0]), 64'(1'b0));
    chk(0, "spur_idle", 64'(busy[0]), 64'(1'b0));
    tick();
    m0_valid = 1'b1;
    m0_addr = 32'h500;
    mem_ready = 1'b1;
    tick();
    tick();
    m0_valid = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk(0, "wait_busy", 64'(busy[0]), 64'(1'b1));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk(0, "rst_busy", 64'(busy[0]), 64'(1'b0));
    chk(0, "rst_sel", 64'(mem_sel[0]), 64'(1'b0));
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    chk(0, "late_rsp_err", 64'(err_unexp[0]), 64'(1'b1));
    tick();
    mem_rvalid = 1'b0;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    mem_ready = 1'b1;
    tick();
    #1;
    chk(0, "post_rst_tie_sel", 64'(mem_sel[0]), 64'(1'b0));
    chk(0, "post_rst_tie_ready", 64'(m0_ready[0]), 64'(1'b1));
    tick();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      if (cons[0] || !m0_valid) begin
        m0_valid = 1'($urandom_range(0, 1));
        m0_addr = $urandom();
        m0_wdata = $urandom();
        m0_we = 1'($urandom_range(0, 1));
        m0_be = BW'($urandom());
      end
      if (cons[1] || !m1_valid) begin
        m1_valid = 1'($urandom_range(0, 1));
        m1_addr = $urandom();
        m1_wdata = $urandom();
        m1_we = 1'($urandom_range(0, 1));
        m1_be = BW'($urandom());
      end
      mem_ready = 1'($urandom_range(0, 1));
      mem_rvalid = $urandom_range(0, 2) == 0;
      mem_rdata = $urandom();
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between instruction fetch (port 0) and load/store (port 1) in the MINIRISC-V core. Arbitrates between the two requesters with round-robin or fixed priority, and drives the select of the request-path 2:1 muxes. Allows one outstanding transaction at a time and routes each response back to the port that issued it. Sits between the IF/MEM pipeline stages and the memory interface.

Parameters:
AW, 32, address width
DW, 32, data width; byte-enable width is DW/8
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 1 (data) always wins

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
m0_valid  input  1  fetch request valid
m0_ready  output  1  fetch request accepted
m0_addr  input  AW  fetch address
m0_wdata  input  DW  fetch write data (unused by IF; tie to 0)
m0_we  input  1  fetch write enable (tie to 0)
m0_be  input  DW/8  fetch byte enables
m0_rvalid  output  1  fetch response pulse
m0_rdata  output  DW  fetch response data
m1_valid/m1_ready/m1_addr/m1_wdata/m1_we/m1_be/m1_rvalid/m1_rdata  same as m0_*, for the load/store port
mem_valid  output  1  request to memory
mem_ready  input  1  memory accepts request
mem_addr  output  AW  muxed address
mem_wdata  output  DW  muxed write data
mem_we  output  1  muxed write enable
mem_be  output  DW/8  muxed byte enables
mem_rvalid  input  1  memory response (read data or write ack)
mem_rdata  input  DW  memory read data
mem_sel  output  1  current owner (0 = fetch, 1 = data); drives the mux Control input
busy  output  1  a transaction is in ISSUE or WAIT
err_unexp  output  1  one-cycle pulse: mem_rvalid arrived in IDLE or ISSUE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, owner=0, last_grant=1, so port 0 wins the first RR tie. All outputs are 0: mem_valid, m*_ready, m*_rvalid, busy, err_unexp, mem_sel.
- FSM state IDLE:
  - If any m*_valid is set, latch the winner into owner and go to ISSUE next cycle.
  - No memory request is driven in IDLE.
  - Request-to-mem_valid latency is 1 cycle.
- Arbitration:
  - One requester valid: it wins.
  - Both valid with RR_EN=1: the port != last_grant wins.
  - Both valid with RR_EN=0: port 1 wins.
- FSM state ISSUE:
  - mem_valid=1. mem_addr/wdata/we/be come from the owner's port, selected by mem_sel=owner.
  - m{owner}_ready = mem_ready; the other port's ready = 0.
  - On mem_valid & mem_ready: go to WAIT and set last_grant=owner.
- FSM state WAIT:
  - mem_valid=0.
  - On mem_rvalid: m{owner}_rvalid=1 for exactly that cycle, then go to IDLE.
  - m0_rdata = m1_rdata = mem_rdata at all times; only rvalid is gated.
  - Write transactions also complete on mem_rvalid (ack).
- busy=1 in ISSUE and WAIT. mem_sel holds owner in ISSUE and WAIT, and keeps its last value in IDLE.
- Back-to-back: there is one IDLE bubble between a response and the next issue. Minimum transaction is 3 cycles with a zero-wait memory.
- Requester protocol:
  - Once valid is asserted, valid and payload stay stable until ready.
  - Dropping valid in ISSUE is illegal; the bench asserts on it, and the arbiter still completes the issue.
- The non-owner may assert or hold valid at any time. It stalls (ready=0) and is never lost.
- mem_rvalid in IDLE or ISSUE: ignored (no m*_rvalid), err_unexp pulses.
- Reset mid-transaction: returns to IDLE immediately. Any in-flight response is dropped; if it arrives after reset, err_unexp pulses.
- Starvation freedom (RR_EN=1): a continuously valid port is granted within 2 transactions.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t
  - localparams PORT_IF=1'b0 and PORT_LS=1'b1
- Sub-module: the existing 2:1 mux, instantiated once per request field (addr, wdata, we, be) with WIDTH set per field and Control=mem_sel. There is no other sub-module.

Test Plan:
- Single fetch: m0_valid, addr=0x0000_0100, mem_ready=1, rdata=0xDEAD_BEEF one cycle after accept -> mem_valid in cycle 1, m0_ready in cycle 1, m0_rvalid with 0xDEADBEEF in cycle 2, busy low in cycle 3.
- Simultaneous continuous requests, RR_EN=1, 4 transactions -> grant order 0,1,0,1; mem_sel follows; each port gets exactly 2 rvalid pulses.
- Same stimulus with RR_EN=0 -> port 1 receives all grants while valid; port 0 m0_ready stays 0.
- Store on port 1 (we=1, be=4'b0011, wdata=0x1234_5678) with mem_ready low for 3 cycles -> mem_valid held 3 cycles with stable payload; m1_ready rises on the accept cycle only; m1_rvalid on ack.
- Spurious mem_rvalid in IDLE -> err_unexp is a 1-cycle pulse, no m*_rvalid, state remains IDLE.
- rst_n asserted during WAIT, then a late mem_rvalid -> all outputs 0 immediately; late response raises err_unexp; next m0 request is served normally with port 0 winning a tie.
